// File: rtl/lwe_pkg.sv
// LWE decrypt shared types and defaults.
// Widths, moduli, rounding constant, FSM states.
package lwe_pkg;

  localparam int unsigned DEF_PW = 6;
  localparam int unsigned DEF_P  = 64;
  localparam int unsigned DEF_CW = 10;
  localparam int unsigned DEF_Q  = 1024;
  localparam int unsigned DEF_N  = 4;

  // Half a plaintext step in ciphertext units: q/(2p).
  localparam int unsigned DEF_RND = DEF_Q / (2 * DEF_P);

  typedef enum logic [1:0] {
    S_ACC  = 2'd0,
    S_BVAL = 2'd1,
    S_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/lwe_round.sv
// Combinational LWE decode: x -> round(x * p / q) mod p.
// The add wraps in CW bits so x near q decodes to 0.
module lwe_round
  import lwe_pkg::*;
#(
  parameter int unsigned PW  = DEF_PW,
  parameter int unsigned CW  = DEF_CW,
  parameter int unsigned RND = DEF_RND
) (
  input  logic [CW-1:0] x,
  output logic [PW-1:0] m
);

  logic [CW-1:0] sum;

  always_comb begin
    sum = x + CW'(RND);
    m   = sum[CW-1:CW-PW];
  end

endmodule

// File: rtl/lwe_decrypt.sv
// Streaming LWE decryption: MAC of a.s, then b - acc decode.
// Frame: n beats of a, one beat of b (in_last), one output.
module lwe_decrypt
  import lwe_pkg::*;
#(
  parameter int unsigned PLAINTEXT_MODULUS  = DEF_P,
  parameter int unsigned PLAINTEXT_WIDTH    = DEF_PW,
  parameter int unsigned CIPHERTEXT_MODULUS = DEF_Q,
  parameter int unsigned CIPHERTEXT_WIDTH   = DEF_CW,
  parameter int unsigned DIMENSION          = DEF_N
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DIMENSION*CIPHERTEXT_WIDTH-1:0] secret_key,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [CIPHERTEXT_WIDTH-1:0]           in_data,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [PLAINTEXT_WIDTH-1:0]            plaintext,
  output logic                                  err
);

  localparam int unsigned CW  = CIPHERTEXT_WIDTH;
  localparam int unsigned PW  = PLAINTEXT_WIDTH;
  localparam int unsigned N   = DIMENSION;
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RND =
    CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS);

  state_e        state_q, state_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] pt_q, pt_d;
  logic          err_q, err_d;

  logic [CW-1:0]   s_sel;
  logic [2*CW-1:0] prod;
  logic [CW-1:0]   x;
  logic [PW-1:0]   m;
  logic            unused_prod_hi;

  always_comb begin
    s_sel = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (idx_q == IW'(i)) s_sel = secret_key[i*CW +: CW];
    end
  end

  // Full-width product; only the low CW bits matter mod q.
  assign prod = {{CW{1'b0}}, in_data} * {{CW{1'b0}}, s_sel};
  assign unused_prod_hi = ^prod[2*CW-1:CW];
  assign x = in_data - acc_q;

  lwe_round #(
    .PW  (PW),
    .CW  (CW),
    .RND (RND)
  ) u_round (
    .x (x),
    .m (m)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    pt_d      = pt_q;
    err_d     = err_q;
    in_ready  = (state_q != S_OUT);
    out_valid = (state_q == S_OUT);
    unique case (state_q)
      S_ACC: begin
        if (in_valid) begin
          if (in_last) begin
            // Early last: drop the beat and restart the frame.
            err_d = 1'b1;
            acc_d = '0;
            idx_d = '0;
          end else begin
            acc_d = acc_q + prod[CW-1:0];
            if (idx_q == IW'(N-1)) begin
              idx_d   = '0;
              state_d = S_BVAL;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
      end
      S_BVAL: begin
        if (in_valid) begin
          if (!in_last) err_d = 1'b1;
          pt_d    = m;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_ACC;
        end
      end
      default: begin
        acc_d   = '0;
        idx_d   = '0;
        state_d = S_ACC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      idx_q   <= '0;
      pt_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      pt_q    <= pt_d;
      err_q   <= err_d;
    end
  end

  assign plaintext = pt_q;
  assign err       = err_q;

endmodule
